// File: rtl/minterm_scan.sv
// minterm_scan: steps W through every code, waits SETTLE cycles,
// samples f into TT[W]. Ports: Clock/Resetn/Start/f in; W/En/TT/Busy/Done out.
module minterm_scan #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Start,
  input  logic            f,
  output logic [N-1:0]    W,
  output logic            En,
  output logic [2**N-1:0] TT,
  output logic            Busy,
  output logic            Done
);

  localparam int M = 2**N;
  localparam logic [N-1:0] WMAX = N'(M - 1);
  localparam logic [3:0] SET = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t         state, state_n;
  logic [3:0]     cnt, cnt_n;
  logic [N-1:0]   w_n;
  logic           en_n, busy_n, done_n;
  logic [M-1:0]   tt_n;
  state_t         first;

  // zero settle time skips straight to sampling
  assign first = (SET == 4'd0) ? S_SAMPLE : S_SETTLE;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      W     <= '0;
      En    <= 1'b0;
      TT    <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      W     <= w_n;
      En    <= en_n;
      TT    <= tt_n;
      Busy  <= busy_n;
      Done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    w_n     = W;
    en_n    = En;
    tt_n    = TT;
    busy_n  = Busy;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        w_n  = '0;
        en_n = 1'b0;
        if (Start) begin
          tt_n    = '0;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = SET;
          state_n = first;
        end
      end
      S_SETTLE: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1)
          state_n = S_SAMPLE;
      end
      S_SAMPLE: begin
        tt_n[W] = f;
        if (W != WMAX) begin
          w_n     = W + N'(1);
          cnt_n   = SET;
          state_n = first;
        end else begin
          w_n     = '0;
          en_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_minterm_scan.sv
// tb_minterm_scan: directed bench for minterm_scan,
// one instance with SETTLE=1 and one with SETTLE=0.
module tb_minterm_scan;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       start1, start0;
  logic       f1, f0;
  logic       fsel;
  logic [2:0] W1, W0;
  logic       En1, En0;
  logic [7:0] TT1, TT0;
  logic       Busy1, Busy0;
  logic       Done1, Done0;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  // reference function: minterms {1,2,4,7} -> 0x96; alt: W[0] -> 0xAA
  assign f1 = fsel ? W1[0]
            : (W1 == 3'd1 || W1 == 3'd2 || W1 == 3'd4 || W1 == 3'd7);

  minterm_scan #(.N(3), .SETTLE(1)) u1 (
    .Clock(Clock), .Resetn(Resetn), .Start(start1), .f(f1),
    .W(W1), .En(En1), .TT(TT1), .Busy(Busy1), .Done(Done1)
  );

  minterm_scan #(.N(3), .SETTLE(0)) u0 (
    .Clock(Clock), .Resetn(Resetn), .Start(start0), .f(f0),
    .W(W0), .En(En0), .TT(TT0), .Busy(Busy0), .Done(Done0)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle1(input string tag);
    chk({tag, "_W"}, 32'(W1), 32'd0);
    chk({tag, "_En"}, 32'(En1), 32'd0);
    chk({tag, "_Busy"}, 32'(Busy1), 32'd0);
    chk({tag, "_Done"}, 32'(Done1), 32'd0);
  endtask

  // pulse start1 so it is accepted at the next edge; returns in cycle 0
  task automatic go1;
    start1 = 1'b1;
    @(negedge Clock);
    start1 = 1'b0;
  endtask

  int bcnt, dcnt, dcyc;
  logic [7:0] ttd;

  initial begin
    Resetn = 1'b0;
    start1 = 1'b0;
    start0 = 1'b0;
    f0 = 1'b1;
    fsel = 1'b0;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    repeat (10) @(negedge Clock);
    idle1("rst");
    chk("rst_TT", 32'(TT1), 32'h00);
    chk("rst_TT0", 32'(TT0), 32'h00);

    // SETTLE=1 scan, each code held two cycles
    go1();
    chk("s1_TT_clr", 32'(TT1), 32'h00);
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("s1_W_c%0d", c), 32'(W1), 32'(c / 2));
      chk($sformatf("s1_En_c%0d", c), 32'(En1), 32'd1);
      chk($sformatf("s1_Busy_c%0d", c), 32'(Busy1), 32'd1);
      chk($sformatf("s1_Done_c%0d", c), 32'(Done1), 32'd0);
      @(negedge Clock);
    end
    chk("s1_Done16", 32'(Done1), 32'd1);
    chk("s1_TT", 32'(TT1), 32'h96);
    chk("s1_W16", 32'(W1), 32'd0);
    chk("s1_En16", 32'(En1), 32'd0);
    chk("s1_Busy16", 32'(Busy1), 32'd0);
    @(negedge Clock);
    idle1("s1_c17");
    chk("s1_TT_hold", 32'(TT1), 32'h96);

    // SETTLE=0 scan, f tied high
    start0 = 1'b1;
    @(negedge Clock);
    start0 = 1'b0;
    bcnt = 0;
    dcnt = 0;
    dcyc = -1;
    ttd = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i < 8)
        chk($sformatf("s0_W_c%0d", i), 32'(W0), 32'(i));
      if (Busy0) bcnt++;
      if (Done0) begin
        dcnt++;
        dcyc = i;
        ttd = TT0;
      end
      @(negedge Clock);
    end
    chk("s0_busy_cycles", 32'(bcnt), 32'd8);
    chk("s0_done_count", 32'(dcnt), 32'd1);
    chk("s0_done_cycle", 32'(dcyc), 32'd8);
    chk("s0_TT", 32'(ttd), 32'hFF);
    chk("s0_TT_hold", 32'(TT0), 32'hFF);

    // Start held high: back-to-back scans
    start1 = 1'b1;
    @(negedge Clock);
    chk("b2b_TT_clr0", 32'(TT1), 32'h00);
    chk("b2b_Busy0", 32'(Busy1), 32'd1);
    repeat (16) @(negedge Clock);
    chk("b2b_Done16", 32'(Done1), 32'd1);
    chk("b2b_TT16", 32'(TT1), 32'h96);
    @(negedge Clock);
    idle1("b2b_c17");
    @(negedge Clock);
    chk("b2b_Busy18", 32'(Busy1), 32'd1);
    chk("b2b_En18", 32'(En1), 32'd1);
    chk("b2b_TT_clr18", 32'(TT1), 32'h00);
    chk("b2b_W18", 32'(W1), 32'd0);
    start1 = 1'b0;
    repeat (16) @(negedge Clock);
    chk("b2b_Done34", 32'(Done1), 32'd1);
    chk("b2b_TT34", 32'(TT1), 32'h96);
    @(negedge Clock);
    idle1("b2b_c35");
    @(negedge Clock);
    chk("b2b_Busy36", 32'(Busy1), 32'd0);

    // Start pulse while W=3 is ignored
    fsel = 1'b1;
    go1();
    repeat (6) @(negedge Clock);
    chk("ign_W3", 32'(W1), 32'd3);
    start1 = 1'b1;
    @(negedge Clock);
    start1 = 1'b0;
    chk("ign_W3b", 32'(W1), 32'd3);
    repeat (9) @(negedge Clock);
    chk("ign_Done16", 32'(Done1), 32'd1);
    chk("ign_TT", 32'(TT1), 32'hAA);
    @(negedge Clock);
    idle1("ign_c17");
    @(negedge Clock);
    chk("ign_Busy18", 32'(Busy1), 32'd0);
    chk("ign_TT_hold", 32'(TT1), 32'hAA);

    // async reset mid-scan at W=5
    fsel = 1'b0;
    go1();
    chk("ar_TT_clr", 32'(TT1), 32'h00);
    repeat (10) @(negedge Clock);
    chk("ar_W5", 32'(W1), 32'd5);
    #2;
    Resetn = 1'b0;
    #1;
    idle1("ar");
    chk("ar_TT", 32'(TT1), 32'h00);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    go1();
    chk("ar2_W0", 32'(W1), 32'd0);
    chk("ar2_Busy0", 32'(Busy1), 32'd1);
    repeat (16) @(negedge Clock);
    chk("ar2_Done16", 32'(Done1), 32'd1);
    chk("ar2_TT", 32'(TT1), 32'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
